// File: rtl/tl_sched_cntr.sv
// tl_sched_cntr: timed two-road traffic-light scheduler with a pedestrian walk phase.
// Green time is arbitrated by the Ta/Tb sensors and bounded by the minimum and maximum green counts.
// Yellow and walk phases have fixed lengths.
// Optional feature macro: TL_ALLRED_EN. When it is defined, an all-red clearance (AR/BR) follows each yellow.
// All outputs are registered and are decoded from the next state, so they always match the current state register.
module tl_sched_cntr #(
  parameter int unsigned GREEN_MIN = 8,
  parameter int unsigned GREEN_MAX = 12,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned WALK_T    = 6,
  parameter int unsigned CNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Ta,
  input  logic       Tb,
  input  logic       ped_req,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic       ped_walk,
  output logic       ped_ack,
  output logic [2:0] state
);

  localparam logic [1:0] GRN = 2'b00;
  localparam logic [1:0] YEL = 2'b01;
  localparam logic [1:0] RED = 2'b10;

  localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  typedef enum logic [2:0] {
    AG = 3'd0,
    AY = 3'd1,
    AR = 3'd2,
    BG = 3'd3,
    BY = 3'd4,
    BR = 3'd5,
    WK = 3'd6
  } state_t;

  state_t           cur_st;
  state_t           nxt_st;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ped_pend;
  logic             ped_pend_nxt;
  logic [1:0]       la_nxt;
  logic [1:0]       lb_nxt;
  logic             walk_nxt;
  logic             ack_nxt;
  logic             walk_entry;

`ifdef TL_ALLRED_EN
  localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALLRED_T - 1);
`else
  // The clearance length has no effect when the all-red phases are removed.
  logic unused_allred;
  assign unused_allred = ^(32'(ALLRED_T));
`endif

  assign state = 3'(cur_st);

  // Next-state selection, phase counter and pedestrian latch update.
  always_comb begin
    nxt_st       = cur_st;
    cnt_nxt      = cnt;
    ped_pend_nxt = ped_pend;
    la_nxt       = RED;
    lb_nxt       = RED;
    walk_nxt     = 1'b0;
    ack_nxt      = 1'b0;
    walk_entry   = 1'b0;

    case (cur_st)
      AG: begin
        if ((cnt >= GMIN_LAST) &&
            ((!Ta && Tb) || ((cnt >= GMAX_LAST) && Tb) || (ped_pend && !Ta)))
          nxt_st = AY;
      end
      AY: begin
`ifdef TL_ALLRED_EN
        if (cnt == YEL_LAST) nxt_st = AR;
`else
        if (cnt == YEL_LAST) nxt_st = BG;
`endif
      end
`ifdef TL_ALLRED_EN
      AR: begin
        if (cnt == AR_LAST) nxt_st = BG;
      end
`endif
      // B yields whenever it has no traffic, which also covers the pedestrian exit; A is the default road.
      BG: begin
        if ((cnt >= GMIN_LAST) && (!Tb || ((cnt >= GMAX_LAST) && Ta)))
          nxt_st = BY;
      end
      BY: begin
`ifdef TL_ALLRED_EN
        if (cnt == YEL_LAST) nxt_st = BR;
`else
        if (cnt == YEL_LAST) nxt_st = ped_pend ? WK : AG;
`endif
      end
`ifdef TL_ALLRED_EN
      BR: begin
        if (cnt == AR_LAST) nxt_st = ped_pend ? WK : AG;
      end
`endif
      WK: begin
        if (cnt == WALK_LAST) nxt_st = AG;
      end
      default: nxt_st = AG;
    endcase

    if (nxt_st != cur_st)
      cnt_nxt = '0;
    else if (cnt != CNT_SAT)
      cnt_nxt = cnt + CNT_W'(1);

    walk_entry = (nxt_st == WK) && (cur_st != WK);
    if (walk_entry)
      ped_pend_nxt = 1'b0;
    else if (ped_req && (cur_st != WK))
      ped_pend_nxt = 1'b1;

    case (nxt_st)
      AG: la_nxt = GRN;
      AY: la_nxt = YEL;
      BG: lb_nxt = GRN;
      BY: lb_nxt = YEL;
      WK: walk_nxt = 1'b1;
      default: ;
    endcase
    ack_nxt = walk_entry;
  end

  // State, counter, pending request and registered light outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_st   <= AG;
      cnt      <= '0;
      ped_pend <= 1'b0;
      La       <= GRN;
      Lb       <= RED;
      ped_walk <= 1'b0;
      ped_ack  <= 1'b0;
    end else begin
      cur_st   <= nxt_st;
      cnt      <= cnt_nxt;
      ped_pend <= ped_pend_nxt;
      La       <= la_nxt;
      Lb       <= lb_nxt;
      ped_walk <= walk_nxt;
      ped_ack  <= ack_nxt;
    end
  end

endmodule

// File: tb/tb_tl_sched_cntr.sv
// Directed bench for tl_sched_cntr: phase sequences are written out as hand-counted runs of states.
module tb_tl_sched_cntr;

  localparam logic [2:0] S_AG = 3'd0;
  localparam logic [2:0] S_AY = 3'd1;
  localparam logic [2:0] S_AR = 3'd2;
  localparam logic [2:0] S_BG = 3'd3;
  localparam logic [2:0] S_BY = 3'd4;
  localparam logic [2:0] S_BR = 3'd5;
  localparam logic [2:0] S_WK = 3'd6;

`ifdef TL_ALLRED_EN
  localparam bit ALLRED = 1'b1;
`else
  localparam bit ALLRED = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic       Ta;
  logic       Tb;
  logic       ped_req;
  logic [1:0] La;
  logic [1:0] Lb;
  logic       ped_walk;
  logic       ped_ack;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  tl_sched_cntr dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .Ta       (Ta),
    .Tb       (Tb),
    .ped_req  (ped_req),
    .La       (La),
    .Lb       (Lb),
    .ped_walk (ped_walk),
    .ped_ack  (ped_ack),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {La, Lb, ped_walk, ped_ack, state} for a state code.
  function automatic logic [8:0] exp_out(input logic [2:0] st, input logic first);
    logic [1:0] la;
    logic [1:0] lb;
    logic       wk;
    la = 2'b10;
    lb = 2'b10;
    wk = 1'b0;
    case (st)
      S_AG: la = 2'b00;
      S_AY: la = 2'b01;
      S_BG: lb = 2'b00;
      S_BY: lb = 2'b01;
      S_WK: wk = 1'b1;
      default: ;
    endcase
    return {la, lb, wk, wk & first, st};
  endfunction

  task automatic chk(input string tag, input logic [2:0] st, input logic first);
    logic [8:0] obs;
    logic [8:0] exp;
    obs = {La, Lb, ped_walk, ped_ack, state};
    exp = exp_out(st, first);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s t=%0t observed %b expected %b", tag, $time, obs, exp);
      end
  endtask

  // Expect state st for n consecutive cycles, sampling at each falling edge.
  task automatic run(input string tag, input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, st, i == 0);
      @(negedge clk);
    end
  endtask

  // Assert reset with the given sensor levels and release it on a falling edge.
  task automatic do_reset(input logic ta, input logic tb);
    reset_n = 1'b0;
    Ta      = ta;
    Tb      = tb;
    ped_req = 1'b0;
    #1;
    chk("reset_vals", S_AG, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    Ta      = 1'b0;
    Tb      = 1'b0;
    ped_req = 1'b0;
    #2;

    // A-only traffic: A stays green.
    do_reset(1'b1, 1'b0);
    run("a_only", S_AG, 40);

    // B-only traffic: minimum green, yellow, optional clearance, then B green.
    do_reset(1'b0, 1'b1);
    run("b_req_ag", S_AG, 8);
    run("b_req_ay", S_AY, 3);
    if (ALLRED) run("b_req_ar", S_AR, 2);
    run("b_req_bg", S_BG, 6);

    // Both roads busy: greens capped at the maximum, alternating.
    do_reset(1'b1, 1'b1);
    run("both_ag1", S_AG, 12);
    run("both_ay1", S_AY, 3);
    if (ALLRED) run("both_ar", S_AR, 2);
    run("both_bg", S_BG, 12);
    run("both_by", S_BY, 3);
    if (ALLRED) run("both_br", S_BR, 2);
    run("both_ag2", S_AG, 12);
    run("both_ay2", S_AY, 1);

    // Pedestrian pulse with no traffic: full cycle, then walk, then A holds.
    do_reset(1'b0, 1'b0);
    run("ped_ag_a", S_AG, 2);
    ped_req = 1'b1;
    run("ped_ag_b", S_AG, 1);
    ped_req = 1'b0;
    run("ped_ag_c", S_AG, 5);
    run("ped_ay", S_AY, 3);
    if (ALLRED) run("ped_ar", S_AR, 2);
    run("ped_bg", S_BG, 8);
    run("ped_by", S_BY, 3);
    if (ALLRED) run("ped_br", S_BR, 2);
    run("ped_wk", S_WK, 6);
    run("ped_after", S_AG, 10);

    // Reset mid-yellow with a pending request: request is lost, sequence restarts.
    do_reset(1'b0, 1'b1);
    run("rst_ag", S_AG, 8);
    run("rst_ay", S_AY, 3);
    if (ALLRED) run("rst_ar", S_AR, 2);
    run("rst_bg", S_BG, 8);
    Tb      = 1'b0;
    ped_req = 1'b1;
    run("rst_bg_exit", S_BG, 1);
    ped_req = 1'b0;
    chk("rst_mid_by", S_BY, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_async", S_AG, 1'b0);
    @(negedge clk);
    #7;
    reset_n = 1'b1;
    @(negedge clk);
    run("rst_hold", S_AG, 10);
    Tb = 1'b1;
    run("rst_b_late", S_AG, 1);
    run("rst_b_ay", S_AY, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
